// File: rtl/writeback_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit_if
//  Description : Bundle of the ALU/load result handshakes, the register-file
//                write port and the hazard/occupancy status of the
//                writeback unit.
//                master : producer side (execute/memory stages, decode)
//                slave  : writeback_unit
//  Revision    : 1.0 - initial release
// ============================================================================
interface writeback_unit_if #(
    parameter int DEPTH = 4
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic               alu_valid;
    logic               alu_ready;
    logic [3:0]         alu_dest;
    logic [17:0]        alu_data;
    logic               mem_valid;
    logic               mem_ready;
    logic [3:0]         mem_dest;
    logic [17:0]        mem_data;
    logic               WriteEnable;
    logic [3:0]         WriteSelect;
    logic [17:0]        WriteData;
    logic [15:0]        pending_mask;
    logic [c_CNT_W-1:0] fifo_count;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        input  alu_ready, mem_ready,
        input  WriteEnable, WriteSelect, WriteData,
        input  pending_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        output alu_ready, mem_ready,
        output WriteEnable, WriteSelect, WriteData,
        output pending_mask, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit
//  Description : Merges single-cycle ALU results and variable-latency load
//                results onto the single register-file write port. Loads
//                wait in a circular FIFO; ALU results bypass it and win
//                unless the FIFO is full or its head has been passed over
//                MAX_WAIT times. pending_mask flags registers with a queued
//                load so decode can stall on hazards.
//  Options     : WB_LOAD_BYPASS_EN - a load arriving with an empty FIFO and
//                no competing ALU result is written directly (1-cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  wire logic       Clock,
    input  wire logic       Clear,
    writeback_unit_if.slave bus
);
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0]  c_FULL     = c_CNT_W'(DEPTH);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

    logic [3:0]          r_dest [DEPTH];
    logic [17:0]         r_data [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_we;
    logic [3:0]          r_sel;
    logic [17:0]         r_wdata;

    logic                w_full;
    logic                w_empty;
    logic                w_prio;
    logic                w_alu_take;
    logic                w_deq;
    logic                w_enq;
    logic                w_bypass;
    logic [15:0]         w_pending;

    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    // A full FIFO or a head skipped MAX_WAIT times blocks the ALU for a cycle
    assign w_prio     = w_full || (r_wait == c_WAIT_MAX);
    assign w_alu_take = bus.alu_valid && !w_prio;
    assign w_deq      = !w_alu_take && !w_empty;

`ifdef WB_LOAD_BYPASS_EN
    assign w_bypass   = w_empty && bus.mem_valid && !w_alu_take;
`else
    assign w_bypass   = 1'b0;
`endif

    // Ready ignores a same-cycle dequeue, so a full FIFO never enqueues
    assign w_enq      = bus.mem_valid && !w_full && !w_bypass;

    assign bus.alu_ready    = !w_prio;
    assign bus.mem_ready    = !w_full;
    assign bus.fifo_count   = r_count;
    assign bus.pending_mask = w_pending;
    assign bus.WriteEnable  = r_we;
    assign bus.WriteSelect  = r_sel;
    assign bus.WriteData    = r_wdata;

    // Hazard mask: OR of one-hot destinations over the occupied entries
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (c_CNT_W'(i) < r_count) begin
                w_pending[r_dest[r_rd_ptr + c_PTR_W'(i)]] = 1'b1;
            end
        end
    end

    // Load FIFO storage, pointers and occupancy
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_dest[r_wr_ptr] <= bus.mem_dest;
                r_data[r_wr_ptr] <= bus.mem_data;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation counter: cycles the non-empty head has been passed over
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_wait <= '0;
        end else if (w_empty || w_deq) begin
            r_wait <= '0;
        end else if (r_wait != c_WAIT_MAX) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // Register-file write port: ALU first, then FIFO head, then direct load
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_wdata <= '0;
        end else if (w_alu_take) begin
            r_we    <= 1'b1;
            r_sel   <= bus.alu_dest;
            r_wdata <= bus.alu_data;
        end else if (w_deq) begin
            r_we    <= 1'b1;
            r_sel   <= r_dest[r_rd_ptr];
            r_wdata <= r_data[r_rd_ptr];
        end else if (w_bypass) begin
            r_we    <= 1'b1;
            r_sel   <= bus.mem_dest;
            r_wdata <= bus.mem_data;
        end else begin
            r_we    <= 1'b0;
        end
    end
endmodule
`default_nettype wire
